// File: rtl/alu_accum_scan_pkg.sv
// Shared definitions for the accumulate-and-display ALU:
// operation codes and the hex 7-segment pattern table.
package alu_accum_scan_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // Active-low segments ordered {a,b,c,d,e,f,g}, indexed by hex nibble.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0000100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b0110001, // C
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

endpackage

// File: rtl/alu_accum_scan_seg_scan.sv
// Time-multiplexed hex display driver: a prescaler holds each digit for
// SCAN_DIV cycles, then the digit index advances and wraps.
module seg_scan
    import alu_accum_scan_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            leds
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    nib;

    // Next-state for the prescaler and the digit index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Scan state registers; reset restarts the scan at digit 0.
    always_ff @(posedge Clock) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (Reset) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    // One-hot digit select plus nibble selection and segment decode.
    always_comb begin
        digit_en = '0;
        nib      = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                digit_en[i] = 1'b1;
                nib         = value[4*i +: 4];
            end
        end
        leds = SEG_LUT[nib];
    end

endmodule

// File: rtl/alu_accum_scan.sv
// Two-stage accumulator ALU: stage 1 registers the operand and op,
// stage 2 executes it into Q with carry/borrow and overflow flags.
// {carryout, Q} is shown on a scanned hex display.
module alu_accum_scan
    import alu_accum_scan_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = (WIDTH + 4) / 4,
    parameter int SCAN_DIV = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   X,
    input  logic               carryin,
    input  logic [1:0]         Op,
    input  logic               Enable,
    output logic [WIDTH-1:0]   Q,
    output logic               carryout,
    output logic               overflow,
    output logic               busy,
    output logic [DIGITS-1:0]  digit_en,
    output logic [6:0]         leds
);

    localparam int MSB = WIDTH - 1;
    localparam int DW  = 4 * DIGITS;

    logic [WIDTH-1:0] xr_q, xr_d;
    logic             cr_q, cr_d;
    op_e              opr_q, opr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum, diff;
    logic [DW-1:0]    disp;

    // Stage 1: capture operand, carry-in and op when enabled; otherwise hold.
    always_comb begin
        xr_d    = xr_q;
        cr_d    = cr_q;
        opr_d   = opr_q;
        valid_d = Enable;
        if (Enable) begin
            xr_d  = X;
            cr_d  = carryin;
            opr_d = op_e'(Op);
        end
    end

    // Stage 2: execute the pending op against the current accumulator.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, xr_q} + {{WIDTH{1'b0}}, cr_q};
        diff    = {1'b0, acc_q} - {1'b0, xr_q} - {{WIDTH{1'b0}}, cr_q};
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (valid_q) begin
            case (opr_q)
                OP_ADD: begin
                    acc_d   = sum[MSB:0];
                    carry_d = sum[WIDTH];
                    ovf_d   = (acc_q[MSB] == xr_q[MSB]) && (sum[MSB] != acc_q[MSB]);
                end
                OP_SUB: begin
                    // Bit WIDTH of the extended difference is set exactly when Q < Xr + cr.
                    acc_d   = diff[MSB:0];
                    carry_d = diff[WIDTH];
                    ovf_d   = (acc_q[MSB] != xr_q[MSB]) && (diff[MSB] != acc_q[MSB]);
                end
                OP_LOAD: begin
                    acc_d   = xr_q;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                default: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // Pipeline and accumulator registers; reset discards any pending op.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: the operand register is reset too, so nothing stale is visible after reset.
            xr_q    <= '0;
            cr_q    <= 1'b0;
            opr_q   <= OP_ADD;
            valid_q <= 1'b0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            xr_q    <= xr_d;
            cr_q    <= cr_d;
            opr_q   <= opr_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q        = acc_q;
    assign carryout = carry_q;
    assign overflow = ovf_q;
    assign busy     = valid_q;
    assign disp     = DW'({carry_q, acc_q});

    seg_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .Clock    (Clock),
        .Reset    (Reset),
        .value    (disp),
        .digit_en (digit_en),
        .leds     (leds)
    );

endmodule

// File: tb/tb_alu_accum_scan.sv
// Self-checking bench for alu_accum_scan (WIDTH=8, DIGITS=3, SCAN_DIV=4):
// directed scenarios followed by random traffic against an arithmetic model.
module tb_alu_accum_scan;

    localparam int W  = 8;
    localparam int ND = 3;
    localparam int SD = 4;

    logic          Clock;
    logic          Reset;
    logic [W-1:0]  X;
    logic          carryin;
    logic [1:0]    Op;
    logic          Enable;
    logic [W-1:0]  Q;
    logic          carryout;
    logic          overflow;
    logic          busy;
    logic [ND-1:0] digit_en;
    logic [6:0]    leds;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int m_q;
    int m_c;
    int m_o;
    int scan_n;
    typedef struct { int x; int c; int op; } op_t;
    op_t in_flight [$];

    // Active-low {a..g} hex digit shapes
    logic [6:0] seg_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    alu_accum_scan #(.WIDTH(W), .DIGITS(ND), .SCAN_DIV(SD)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .X        (X),
        .carryin  (carryin),
        .Op       (Op),
        .Enable   (Enable),
        .Q        (Q),
        .carryout (carryout),
        .overflow (overflow),
        .busy     (busy),
        .digit_en (digit_en),
        .leds     (leds)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int s8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Execute one op on the model accumulator using plain integer arithmetic.
    task automatic apply(input op_t o);
        int r, s;
        case (o.op)
            0: begin
                r   = m_q + o.x + o.c;
                s   = s8(m_q) + s8(o.x) + o.c;
                m_c = (r > 255) ? 1 : 0;
                m_o = (s > 127 || s < -128) ? 1 : 0;
                m_q = r % 256;
            end
            1: begin
                r   = m_q - o.x - o.c;
                s   = s8(m_q) - s8(o.x) - o.c;
                m_c = (m_q < o.x + o.c) ? 1 : 0;
                m_o = (s > 127 || s < -128) ? 1 : 0;
                m_q = (r + 512) % 256;
            end
            2: begin m_q = o.x; m_c = 0; m_o = 0; end
            default: begin m_q = 0; m_c = 0; m_o = 0; end
        endcase
    endtask

    task automatic check_all();
        int d, dig, nib;
        d   = m_c * 256 + m_q;
        dig = (scan_n / SD) % ND;
        nib = (d >> (4 * dig)) & 15;
        check("Q", 32'(Q), 32'(m_q));
        check("carryout", 32'(carryout), 32'(m_c));
        check("overflow", 32'(overflow), 32'(m_o));
        check("busy", 32'(busy), (in_flight.size() != 0) ? 32'd1 : 32'd0);
        check("digit_en", 32'(digit_en), 32'(1 << dig));
        check("leds", 32'(leds), 32'(seg_ref[nib]));
    endtask

    // One clock: drive inputs, advance the model across the edge, then check.
    task automatic step(input bit rst, input bit en, input int x, input int c, input int op);
        op_t o;
        Reset   = rst;
        Enable  = en;
        X       = W'(x);
        carryin = c[0];
        Op      = op[1:0];
        @(posedge Clock);
        if (rst) begin
            m_q = 0; m_c = 0; m_o = 0; scan_n = 0;
            in_flight.delete();
        end else begin
            if (in_flight.size() != 0) apply(in_flight.pop_front());
            if (en) begin
                o.x = x; o.c = c; o.op = op;
                in_flight.push_back(o);
            end
            scan_n++;
        end
        @(negedge Clock);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; X = '0; carryin = 1'b0; Op = 2'b00;
        m_q = 0; m_c = 0; m_o = 0; scan_n = 0;

        // Reset held for two cycles
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_digit_en", 32'(digit_en), 32'h1);
        check("rst_leds", 32'(leds), 32'h01);

        // LOAD 7F then ADD 01: signed overflow into 80
        step(0, 1, 'h7F, 0, 2);
        check("la_busy1", 32'(busy), 32'h1);
        step(0, 1, 'h01, 0, 0);
        check("la_q1", 32'(Q), 32'h7F);
        check("la_busy2", 32'(busy), 32'h1);
        step(0, 0, 0, 0, 0);
        check("la_q2", 32'(Q), 32'h80);
        check("la_ovf", 32'(overflow), 32'h1);
        check("la_cout", 32'(carryout), 32'h0);
        check("la_busy3", 32'(busy), 32'h0);

        // ADD F0 twice from zero: carry out on the second
        step(1, 0, 0, 0, 0);
        step(0, 1, 'hF0, 0, 0);
        step(0, 1, 'hF0, 0, 0);
        check("af_q1", 32'(Q), 32'hF0);
        check("af_c1", 32'(carryout), 32'h0);
        step(0, 0, 0, 0, 0);
        check("af_q2", 32'(Q), 32'hE0);
        check("af_c2", 32'(carryout), 32'h1);
        check("af_o2", 32'(overflow), 32'h0);

        // LOAD 05, SUB 07 borrows to FE; CLEAR zeroes everything
        step(0, 1, 'h05, 0, 2);
        step(0, 1, 'h07, 0, 1);
        step(0, 1, 0, 0, 3);
        check("sub_q", 32'(Q), 32'hFE);
        check("sub_c", 32'(carryout), 32'h1);
        check("sub_o", 32'(overflow), 32'h0);
        step(0, 0, 0, 0, 0);
        check("clr_q", 32'(Q), 32'h00);
        check("clr_c", 32'(carryout), 32'h0);

        // Q=A5 with carry=1, then watch a full scan period
        step(1, 0, 0, 0, 0);
        step(0, 1, 'hFF, 0, 2);
        step(0, 1, 'hA5, 1, 0);
        step(0, 0, 0, 0, 0);
        check("scan_q", 32'(Q), 32'hA5);
        check("scan_c", 32'(carryout), 32'h1);
        idle(3 * SD * 2);

        // Operand captured, then reset discards it
        step(1, 0, 0, 0, 0);
        step(0, 1, 'h10, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rmid_busy", 32'(busy), 32'h0);
        idle(4);
        check("rmid_q", 32'(Q), 32'h00);

        // Enable on the same edge as reset is ignored
        step(1, 1, 'h44, 0, 2);
        idle(3);
        check("ren_q", 32'(Q), 32'h00);

        // Hold with Enable low for ten cycles
        step(0, 1, 'h33, 0, 2);
        idle(1);
        check("hold_q0", 32'(Q), 32'h33);
        idle(10);
        check("hold_q1", 32'(Q), 32'h33);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
